// File: rtl/counter_pkg.sv
// Shared constants and types for the parametrised up/down counter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package counter_pkg;

    // Boundary behaviour selected by the mode input
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    // Counting direction encoding (matches the op input and dir output)
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // One-shot control state: counting, or parked after a one-shot event
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/addsub_step.sv
// Candidate next count value plus overflow/underflow detection for one step.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are.
module addsub_step
    import counter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 8
) (
    input  logic [WIDTH-1:0]  c,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lim,
    input  logic              dir,
    output logic [WIDTH:0]    nxt,
    output logic              ovf,
    output logic              unf
);

    // One extra bit so an up-count past lim or a down-count below 0 is visible
    logic [WIDTH:0] c_ext;
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] lim_ext;

    assign c_ext    = {1'b0, c};
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign lim_ext  = {1'b0, lim};

    // Add or subtract the step and flag crossing of the active bound
    always_comb begin
        nxt = c_ext;
        ovf = 1'b0;
        unf = 1'b0;
        if (dir == DIR_UP) begin
            nxt = c_ext + step_ext;
            ovf = (nxt > lim_ext);
        end else begin
            nxt = c_ext - step_ext;
            unf = (step_ext > c_ext);
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Up/down counter with programmable step and limit; wrap/saturate/bounce/one-shot bounds.
// Latency: c_out, tc, dir, done update one clock after the controlling inputs.
// Backpressure: none; en is sampled every cycle, and ignored while a one-shot is done.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int              WIDTH       = 16,
    parameter int              STEP_W      = 8,
    parameter logic [WIDTH-1:0] DEFAULT_LIM = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              op,
    input  logic [1:0]        mode,
    input  logic              c_ld,
    input  logic              c_clr,
    input  logic              lim_ld,
    input  logic [WIDTH-1:0]  d_in,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  c_out,
    output logic              z,
    output logic              m,
    output logic              tc,
    output logic              dir,
    output logic              done
);

    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] lim_q;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    state_t           state_q, state_d;

    logic             eff_dir;
    logic [WIDTH:0]   nxt;
    logic             ovf, unf;
    logic             count_cyc;
    logic             oneshot_evt;
    logic [WIDTH-1:0] bound;

    // Bounce mode follows its own ping-pong direction; other modes follow op directly
    assign eff_dir   = (mode == MODE_BOUNCE) ? dir_q : op;
    assign count_cyc = en && (state_q == ST_RUN);
    assign bound     = (eff_dir == DIR_UP) ? lim_q : '0;

    addsub_step #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_addsub (
        .c    (c_q),
        .step (step),
        .lim  (lim_q),
        .dir  (eff_dir),
        .nxt  (nxt),
        .ovf  (ovf),
        .unf  (unf)
    );

    // Next counter/direction/pulse values: clear > load > count, then mode-specific bounds
    always_comb begin
        c_d         = c_q;
        tc_d        = 1'b0;
        dir_d       = eff_dir;
        oneshot_evt = 1'b0;
        if (c_clr) begin
            c_d   = '0;
            dir_d = op;
        end else if (c_ld) begin
            c_d   = (d_in > lim_q) ? lim_q : d_in;
            dir_d = op;
        end else if (count_cyc && (step != '0)) begin
            if (c_q > lim_q) begin
                // Limit was lowered beneath the count: pull back to it as an event
                c_d  = lim_q;
                tc_d = 1'b1;
            end else if (ovf || unf) begin
                case (mode)
                    MODE_WRAP: begin
                        c_d  = (eff_dir == DIR_UP) ? '0 : lim_q;
                        tc_d = 1'b1;
                    end
                    MODE_SAT: begin
                        c_d  = bound;
                        tc_d = (c_q != bound);
                    end
                    MODE_BOUNCE: begin
                        c_d   = bound;
                        dir_d = ~dir_q;
                        tc_d  = 1'b1;
                    end
                    default: begin
                        c_d         = bound;
                        oneshot_evt = 1'b1;
                        tc_d        = 1'b1;
                    end
                endcase
            end else if (!nxt[WIDTH]) begin
                // In range: carry bit is always clear here, guard kept for clarity
                c_d = nxt[WIDTH-1:0];
            end
        end
    end

    // State register for the one-shot control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: park on a one-shot event, leave only via clear or load
    always_comb begin
        state_d = state_q;
        if (c_clr || c_ld) begin
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && oneshot_evt) begin
            state_d = ST_DONE;
        end
    end

    // FSM output: done is sticky for as long as the FSM is parked
    always_comb begin
        done = (state_q == ST_DONE);
    end

    // Datapath registers: counter, limit, direction and terminal-count pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= '0;
            lim_q <= DEFAULT_LIM;
            dir_q <= DIR_UP;
            tc_q  <= 1'b0;
        end else begin
            c_q   <= c_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
            if (lim_ld) begin
                lim_q <= d_in;
            end
        end
    end

    assign c_out = c_q;
    assign z     = (c_q == '0);
    assign m     = (c_q == lim_q);
    assign tc    = tc_q;
    assign dir   = dir_q;

endmodule
